// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - signal bundle between the ATM session controller and its surroundings
// The master side is the environment (card reader, keypad, account store,
// inactivity timer, transaction engine); the slave side is the controller.
interface atm_session_ctrl_if #(
  parameter int PIN_W = 16
);
  // Card mechanism, keypad and account store
  logic             card_in;
  logic             pin_valid;
  logic [PIN_W-1:0] pin_in;
  logic [PIN_W-1:0] stored_pin;
  logic             op_valid;
  logic [1:0]       op_code;

  // Transaction engine and inactivity timer feedback
  logic             txn_done;
  logic             timeout;

  // Controller outputs
  logic             timer_start;
  logic             timer_restart;
  logic [31:0]      timer_threshold;
  logic             txn_go;
  logic [1:0]       txn_op;
  logic             card_eject;
  logic             card_retain;
  logic [2:0]       state_o;
  logic [1:0]       attempts_left;

  modport master (
    output card_in, pin_valid, pin_in, stored_pin, op_valid, op_code,
           txn_done, timeout,
    input  timer_start, timer_restart, timer_threshold, txn_go, txn_op,
           card_eject, card_retain, state_o, attempts_left
  );

  modport slave (
    input  card_in, pin_valid, pin_in, stored_pin, op_valid, op_code,
           txn_done, timeout,
    output timer_start, timer_restart, timer_threshold, txn_go, txn_op,
           card_eject, card_retain, state_o, attempts_left
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session controller (card, PIN, menu, transaction hand-off; PIN_LOCKOUT_EN enables attempt limiting)
module atm_session_ctrl #(
  parameter int          PIN_W        = 16,
  parameter int          MAX_ATTEMPTS = 3,
  parameter logic [31:0] PIN_TIMEOUT  = 32'd100,
  parameter logic [31:0] MENU_TIMEOUT = 32'd200
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN_WAIT = 3'd1,
    S_MENU     = 3'd2,
    S_TXN_BUSY = 3'd3,
    S_EJECT    = 3'd4,
    S_RETAIN   = 3'd5
  } state_e;

  localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

  state_e      state_q, state_d;
  logic [1:0]  attempts_q, attempts_d;
  logic [1:0]  txn_op_q, txn_op_d;
  logic [31:0] threshold_q, threshold_d;
  logic        timer_start_q, timer_start_d;
  logic        timer_restart_q, timer_restart_d;
  logic        txn_go_q, txn_go_d;
  logic        card_eject_q, card_eject_d;
  logic        card_retain_q, card_retain_d;

  logic [PIN_W-1:0] pin_entered;
  logic [PIN_W-1:0] pin_account;
  logic             pin_match;
  logic             timeout_live;
  logic             wrong_pin;
  logic             timing_d;

  assign pin_entered = bus.pin_in;
  assign pin_account = bus.stored_pin;
  assign pin_match   = (pin_entered == pin_account);

  // An expiry only counts while the timer was running and not being cleared,
  // so a count left over from the previous phase cannot abort the new one.
  assign timeout_live = bus.timeout & timer_start_q & ~timer_restart_q;

  // Session sequencing and the registered outputs that follow from the next state
  always_comb begin
    state_d     = state_q;
    attempts_d  = attempts_q;
    txn_op_d    = txn_op_q;
    threshold_d = threshold_q;
    wrong_pin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.card_in) begin
          state_d     = S_PIN_WAIT;
          attempts_d  = MAX_ATT;
          threshold_d = PIN_TIMEOUT;
        end
      end

      S_PIN_WAIT: begin
        if (!bus.card_in) begin
          state_d = S_IDLE;
        end else if (bus.pin_valid) begin
          if (pin_match) begin
            state_d     = S_MENU;
            threshold_d = MENU_TIMEOUT;
          end else begin
            wrong_pin = 1'b1;
`ifdef PIN_LOCKOUT_EN
            if (attempts_q != 2'd0) begin
              attempts_d = attempts_q - 2'd1;
            end
            if (attempts_q <= 2'd1) begin
              state_d = S_RETAIN;
            end
`endif
          end
        end else if (timeout_live) begin
          state_d = S_EJECT;
        end
      end

      S_MENU: begin
        if (!bus.card_in) begin
          state_d = S_IDLE;
        end else if (bus.op_valid) begin
          if (bus.op_code == 2'd3) begin
            state_d = S_EJECT;
          end else begin
            state_d  = S_TXN_BUSY;
            txn_op_d = bus.op_code;
          end
        end else if (timeout_live) begin
          state_d = S_EJECT;
        end
      end

      // The card is mechanically locked while the engine works, so card_in
      // and the timer are deliberately not looked at here.
      S_TXN_BUSY: begin
        if (bus.txn_done) begin
          state_d = S_MENU;
        end
      end

      S_EJECT, S_RETAIN: begin
        if (!bus.card_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifndef PIN_LOCKOUT_EN
    attempts_d = MAX_ATT;
`endif

    // Timer runs only in the two waiting phases; it is cleared everywhere
    // else, and for one cycle on each entry to a waiting phase or bad PIN.
    timing_d        = (state_d == S_PIN_WAIT) || (state_d == S_MENU);
    timer_start_d   = timing_d;
    timer_restart_d = !timing_d || (state_d != state_q) || wrong_pin;

    txn_go_d      = (state_q == S_MENU) && (state_d == S_TXN_BUSY);
    card_eject_d  = (state_d == S_EJECT);
    card_retain_d = (state_d == S_RETAIN);
  end

  // All state and outputs are registered; reset aborts the session with no eject
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      attempts_q      <= MAX_ATT;
      txn_op_q        <= 2'd0;
      threshold_q     <= PIN_TIMEOUT;
      timer_start_q   <= 1'b0;
      timer_restart_q <= 1'b1;
      txn_go_q        <= 1'b0;
      card_eject_q    <= 1'b0;
      card_retain_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      attempts_q      <= attempts_d;
      txn_op_q        <= txn_op_d;
      threshold_q     <= threshold_d;
      timer_start_q   <= timer_start_d;
      timer_restart_q <= timer_restart_d;
      txn_go_q        <= txn_go_d;
      card_eject_q    <= card_eject_d;
      card_retain_q   <= card_retain_d;
    end
  end

  assign bus.state_o         = state_q;
  assign bus.attempts_left   = attempts_q;
  assign bus.txn_op          = txn_op_q;
  assign bus.timer_threshold = threshold_q;
  assign bus.timer_start     = timer_start_q;
  assign bus.timer_restart   = timer_restart_q;
  assign bus.txn_go          = txn_go_q;
  assign bus.card_eject      = card_eject_q;
  assign bus.card_retain     = card_retain_q;

endmodule
